// File: rtl/uart_pkg.sv
// Shared constants, interrupt-level encoding and threshold helper for the UART FIFOs.
package uart_pkg;

  localparam int unsigned UART_FIFO_DEPTH = 16;
  localparam int unsigned UART_FIFO_WIDTH = 8;

  typedef enum logic [2:0] {
    IFL_1_8 = 3'b000,
    IFL_1_4 = 3'b001,
    IFL_1_2 = 3'b010,
    IFL_3_4 = 3'b011,
    IFL_7_8 = 3'b100
  } uart_ifl_e;

  // Threshold in entries; reserved codes fall back to half full.
  function automatic int unsigned ifl_threshold(input logic [2:0] ifl_sel,
                                                input int unsigned depth);
    int unsigned k;
    case (uart_ifl_e'(ifl_sel))
      IFL_1_8: k = 1;
      IFL_1_4: k = 2;
      IFL_1_2: k = 4;
      IFL_3_4: k = 6;
      IFL_7_8: k = 7;
      default: k = 4;
    endcase
    return (depth / 8) * k;
  endfunction

endpackage

// File: rtl/uart_fifo_mem.sv
// DEPTH x WIDTH register file: one synchronous write port, one asynchronous read port.
module uart_fifo_mem
  import uart_pkg::*;
#(
  parameter int unsigned DEPTH = UART_FIFO_DEPTH,
  parameter int unsigned WIDTH = UART_FIFO_WIDTH
) (
  input  logic                     CLK,
  input  logic                     RSTn,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  logic [WIDTH-1:0]         wdata,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  output logic [WIDTH-1:0]         rdata
);

  logic [WIDTH-1:0] mem_q [DEPTH];

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
    end else if (we) begin
      mem_q[waddr] <= wdata;
    end
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/uart_tx_fifo.sv
// UART transmit FIFO: buffers UARTDR writes, hands the head byte to the transmitter,
// and produces the TXFF/TXFE flags and TX interrupt level.
module uart_tx_fifo
  import uart_pkg::*;
#(
  parameter int unsigned DEPTH = UART_FIFO_DEPTH,
  parameter int unsigned WIDTH = UART_FIFO_WIDTH
) (
  input  logic                   CLK,
  input  logic                   RSTn,
  input  logic [WIDTH-1:0]       wr_data,
  input  logic                   wr_en,
  input  logic                   fifo_en,
  input  logic [2:0]             ifl_sel,
  output logic [WIDTH-1:0]       fifo_data,
  output logic                   fifo_data_valid,
  input  logic                   fifo_data_taken,
  output logic                   tx_full,
  output logic                   tx_empty,
  output logic                   tx_int_level,
  output logic                   wr_overflow,
  output logic [$clog2(DEPTH):0] level
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned LW = PW + 1;

  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic          fifo_en_q;
  logic          flush;
  logic [LW-1:0] cap;
  logic [LW-1:0] th;
  logic          full;
  logic          push;
  logic          pop;
  logic          drop;

  // Any fifo_en edge flushes; a pop frees the slot a same-cycle write needs.
  always_comb begin
    flush = fifo_en ^ fifo_en_q;
    cap   = fifo_en ? LW'(DEPTH) : LW'(1);
    th    = LW'(ifl_threshold(ifl_sel, DEPTH));
    full  = (level >= cap);
    pop   = fifo_data_taken && (level != '0) && !flush;
    push  = wr_en && !flush && (!full || pop);
    drop  = wr_en && !flush && full && !pop;
  end

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      level       <= '0;
      fifo_en_q   <= 1'b0;
      wr_overflow <= 1'b0;
    end else begin
      fifo_en_q   <= fifo_en;
      wr_overflow <= drop;
      if (flush) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        level  <= '0;
      end else begin
        if (push) wr_ptr <= wr_ptr + PW'(1);
        if (pop)  rd_ptr <= rd_ptr + PW'(1);
        if (push && !pop)      level <= level + LW'(1);
        else if (pop && !push) level <= level - LW'(1);
      end
    end
  end

  uart_fifo_mem #(
    .DEPTH (DEPTH),
    .WIDTH (WIDTH)
  ) u_mem (
    .CLK   (CLK),
    .RSTn  (RSTn),
    .we    (push),
    .waddr (wr_ptr),
    .wdata (wr_data),
    .raddr (rd_ptr),
    .rdata (fifo_data)
  );

  assign fifo_data_valid = (level != '0);
  assign tx_empty        = (level == '0);
  assign tx_full         = (level == cap);
  assign tx_int_level    = fifo_en ? (level <= th) : (level == '0);

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed bench for uart_tx_fifo; popped bytes are checked against a scoreboard queue.
module tb_uart_tx_fifo;

  logic       CLK = 1'b0;
  logic       RSTn;
  logic [7:0] wr_data;
  logic       wr_en;
  logic       fifo_en;
  logic [2:0] ifl_sel;
  logic [7:0] fifo_data;
  logic       fifo_data_valid;
  logic       fifo_data_taken;
  logic       tx_full;
  logic       tx_empty;
  logic       tx_int_level;
  logic       wr_overflow;
  logic [4:0] level;

  int checks   = 0;
  int failures = 0;
  logic [7:0] exp_q[$];

  always #5 CLK = ~CLK;

  uart_tx_fifo #(.DEPTH(16), .WIDTH(8)) dut (
    .CLK             (CLK),
    .RSTn            (RSTn),
    .wr_data         (wr_data),
    .wr_en           (wr_en),
    .fifo_en         (fifo_en),
    .ifl_sel         (ifl_sel),
    .fifo_data       (fifo_data),
    .fifo_data_valid (fifo_data_valid),
    .fifo_data_taken (fifo_data_taken),
    .tx_full         (tx_full),
    .tx_empty        (tx_empty),
    .tx_int_level    (tx_int_level),
    .wr_overflow     (wr_overflow),
    .level           (level)
  );

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
    end
  endtask

  // One clock of stimulus; acc says whether the written byte must later be read out.
  task automatic cyc(input logic we, input logic [7:0] d, input logic tk, input logic acc);
    wr_en           = we;
    wr_data         = d;
    fifo_data_taken = tk;
    if (acc) exp_q.push_back(d);
    @(posedge CLK);
    #1;
    wr_en           = 1'b0;
    fifo_data_taken = 1'b0;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_data"},     int'(fifo_data), 0);
    chk({tag, "_valid"},    int'(fifo_data_valid), 0);
    chk({tag, "_empty"},    int'(tx_empty), 1);
    chk({tag, "_full"},     int'(tx_full), 0);
    chk({tag, "_int"},      int'(tx_int_level), 1);
    chk({tag, "_overflow"}, int'(wr_overflow), 0);
    chk({tag, "_level"},    int'(level), 0);
  endtask

  // Monitor: each accepted pop must present the oldest expected byte.
  always @(negedge CLK) begin
    if (RSTn && fifo_data_taken && fifo_data_valid) begin
      if (exp_q.size() == 0) begin
        chk("pop_unexpected", int'(fifo_data), -1);
      end else begin
        chk("pop_data", int'(fifo_data), int'(exp_q.pop_front()));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    RSTn = 1'b0; wr_en = 1'b0; wr_data = '0; fifo_en = 1'b0;
    ifl_sel = 3'b000; fifo_data_taken = 1'b0;
    repeat (2) @(posedge CLK);
    #1;
    chk_reset_vals("reset");
    RSTn = 1'b1;
    fifo_en = 1'b1;
    cyc(1'b0, 8'h00, 1'b0, 1'b0);

    // 1: three writes then three ordered pops
    cyc(1'b1, 8'h41, 1'b0, 1'b1);
    cyc(1'b1, 8'h42, 1'b0, 1'b1);
    cyc(1'b1, 8'h43, 1'b0, 1'b1);
    chk("t1_level", int'(level), 3);
    chk("t1_head", int'(fifo_data), 8'h41);
    chk("t1_valid", int'(fifo_data_valid), 1);
    repeat (3) cyc(1'b0, 8'h00, 1'b1, 1'b0);
    chk("t1_empty", int'(tx_empty), 1);

    // 2: fill to 16, 17th write overflows
    for (int i = 0; i < 16; i++) begin
      cyc(1'b1, 8'(8'h10 + i), 1'b0, 1'b1);
      if (i == 14) chk("t2_notfull15", int'(tx_full), 0);
    end
    chk("t2_full", int'(tx_full), 1);
    chk("t2_level16", int'(level), 16);
    cyc(1'b1, 8'hEE, 1'b0, 1'b0);
    chk("t2_ovf_pulse", int'(wr_overflow), 1);
    chk("t2_level_after", int'(level), 16);
    cyc(1'b0, 8'h00, 1'b0, 1'b0);
    chk("t2_ovf_clear", int'(wr_overflow), 0);
    chk("t2_head", int'(fifo_data), 8'h10);

    // 3: write and pop together while full
    cyc(1'b1, 8'hA5, 1'b1, 1'b1);
    chk("t3_level", int'(level), 16);
    chk("t3_no_ovf", int'(wr_overflow), 0);
    chk("t3_head", int'(fifo_data), 8'h11);
    repeat (16) cyc(1'b0, 8'h00, 1'b1, 1'b0);
    chk("t3_empty", int'(tx_empty), 1);

    // 4: threshold 8 with ifl_sel=010
    ifl_sel = 3'b010;
    #1;
    chk("t4_int_l0", int'(tx_int_level), 1);
    for (int i = 1; i <= 9; i++) begin
      cyc(1'b1, 8'(8'h60 + i), 1'b0, 1'b1);
      chk($sformatf("t4_int_l%0d", i), int'(tx_int_level), (i <= 8) ? 1 : 0);
    end
    cyc(1'b0, 8'h00, 1'b1, 1'b0);
    chk("t4_int_after_pop", int'(tx_int_level), 1);
    chk("t4_level8", int'(level), 8);
    repeat (8) cyc(1'b0, 8'h00, 1'b1, 1'b0);
    chk("t4_empty", int'(tx_empty), 1);

    // 5: holding-register mode
    fifo_en = 1'b0;
    cyc(1'b0, 8'h00, 1'b0, 1'b0);
    cyc(1'b1, 8'h55, 1'b0, 1'b1);
    chk("t5_full", int'(tx_full), 1);
    chk("t5_int", int'(tx_int_level), 0);
    cyc(1'b1, 8'h66, 1'b0, 1'b0);
    chk("t5_ovf", int'(wr_overflow), 1);
    chk("t5_level", int'(level), 1);
    cyc(1'b0, 8'h00, 1'b1, 1'b0);
    chk("t5_empty", int'(tx_empty), 1);
    chk("t5_int_empty", int'(tx_int_level), 1);

    // 6: flush on fifo_en toggle, write in the flush cycle discarded
    fifo_en = 1'b1;
    cyc(1'b0, 8'h00, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) cyc(1'b1, 8'(8'h80 + i), 1'b0, 1'b0);
    chk("t6_level5", int'(level), 5);
    fifo_en = 1'b0;
    cyc(1'b1, 8'h99, 1'b0, 1'b0);
    chk("t6_flush_level", int'(level), 0);
    chk("t6_flush_valid", int'(fifo_data_valid), 0);
    chk("t6_flush_empty", int'(tx_empty), 1);

    // Async reset mid-operation
    fifo_en = 1'b1;
    cyc(1'b0, 8'h00, 1'b0, 1'b0);
    cyc(1'b1, 8'hC1, 1'b0, 1'b0);
    cyc(1'b1, 8'hC2, 1'b0, 1'b0);
    chk("t6_pre_rst_level", int'(level), 2);
    #2;
    RSTn = 1'b0;
    #1;
    chk_reset_vals("async_rst");
    @(posedge CLK);
    #1;
    RSTn = 1'b1;
    cyc(1'b0, 8'h00, 1'b0, 1'b0);
    cyc(1'b1, 8'h77, 1'b0, 1'b1);
    chk("post_rst_head", int'(fifo_data), 8'h77);
    cyc(1'b0, 8'h00, 1'b1, 1'b0);
    chk("post_rst_empty", int'(tx_empty), 1);

    chk("scoreboard_drained", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
